// File: rtl/char_pkg.sv
// Shared state encoding, screen defaults and the X clamping helper
// for the player-character controller.
package char_pkg;

    typedef enum logic [1:0] {PRE, PLAY, INVULN, OVER} state_t;

    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned SCREEN_H_DEF = 480;

    // dir is {left, right}; only a single held direction moves the character.
    // Right is summed in 12 bits and left compares before subtracting, so X never wraps.
    function automatic logic [10:0] clamp_x(input logic [10:0] x,
                                            input logic [10:0] step,
                                            input logic [1:0]  dir,
                                            input logic [10:0] maxX);
        logic [11:0] sum;
        sum = {1'b0, x} + {1'b0, step};
        case (dir)
            2'b01:   clamp_x = (sum > {1'b0, maxX}) ? maxX : sum[10:0];
            2'b10:   clamp_x = (x < step) ? '0 : x - step;
            default: clamp_x = x;
        endcase
    endfunction

endpackage

// File: rtl/invuln_timer.sv
// Frame-counted down-counter for the post-hit invulnerability window.
// toggle marks every counted frame; done marks the frame that reaches zero.
module invuln_timer #(
    parameter int unsigned FRAMES = 60
) (
    input  logic clk,
    input  logic resetN,
    input  logic load,
    input  logic startOfFrame,
    input  logic count,
    output logic done,
    output logic toggle
);

    logic [7:0] cnt_q, cnt_d;

    assign toggle = count && startOfFrame;
    assign done   = toggle && (cnt_q == 8'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = 8'(FRAMES);
        else if (toggle && (cnt_q != '0))
            cnt_d = cnt_q - 8'd1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/char_ctrl.sv
// Player-character controller: horizontal movement on the floor, lives,
// and the post-hit invulnerability/blink window. All outputs are registered.
module char_ctrl
    import char_pkg::*;
#(
    parameter int unsigned SCREEN_W      = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H      = SCREEN_H_DEF,
    parameter int unsigned CHAR_WIDTH    = 20,
    parameter int unsigned CHAR_HEIGHT   = 32,
    parameter int unsigned STEP          = 1,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned INITIAL_X     = 320
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        leftPress,
    input  logic        rightPress,
    input  logic        bubbleHit,
    input  logic        start,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        visible,
    output logic [3:0]  livesLeft,
    output logic        hitPulse,
    output logic        gameOver
);

    localparam logic [10:0] MAX_X   = 11'(SCREEN_W - CHAR_WIDTH);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] SPAWN_X = 11'(INITIAL_X);
    localparam logic [10:0] FLOOR_Y = 11'(SCREEN_H - 1 - CHAR_HEIGHT);
    localparam logic [3:0]  LIVES_W = 4'(LIVES);

    state_t      state_q;
    logic [10:0] x_q;
    logic        vis_q;
    logic [3:0]  lives_q;
    logic        hit_q;
    logic        over_q;

    logic        hit_accept;
    logic        tmr_load;
    logic        tmr_done;
    logic        tmr_toggle;
    logic [10:0] x_moved;

    assign hit_accept = (state_q == PLAY) && bubbleHit;
    assign tmr_load   = hit_accept && (lives_q != 4'd1);
    assign x_moved    = clamp_x(x_q, STEP_W, {leftPress, rightPress}, MAX_X);

    invuln_timer #(
        .FRAMES(INVULN_FRAMES)
    ) u_timer (
        .clk         (clk),
        .resetN      (resetN),
        .load        (tmr_load),
        .startOfFrame(startOfFrame),
        .count       (state_q == INVULN),
        .done        (tmr_done),
        .toggle      (tmr_toggle)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= PRE;
            x_q     <= SPAWN_X;
            vis_q   <= 1'b1;
            lives_q <= LIVES_W;
            hit_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            case (state_q)
                PRE: begin
                    x_q     <= SPAWN_X;
                    lives_q <= LIVES_W;
                    vis_q   <= 1'b1;
                    over_q  <= 1'b0;
                    if (start)
                        state_q <= PLAY;
                end
                PLAY: begin
                    // A hit takes priority over a frame's movement in the same cycle.
                    if (hit_accept) begin
                        hit_q   <= 1'b1;
                        lives_q <= lives_q - 4'd1;
                        if (lives_q == 4'd1) begin
                            state_q <= OVER;
                            over_q  <= 1'b1;
                            vis_q   <= 1'b0;
                        end else begin
                            state_q <= INVULN;
                        end
                    end else if (startOfFrame) begin
                        x_q <= x_moved;
                    end
                end
                INVULN: begin
                    if (startOfFrame)
                        x_q <= x_moved;
                    if (tmr_done) begin
                        state_q <= PLAY;
                        vis_q   <= 1'b1;
                    end else if (tmr_toggle) begin
                        vis_q <= ~vis_q;
                    end
                end
                OVER: begin
                    if (start) begin
                        state_q <= PRE;
                        over_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign topLeftX  = x_q;
    assign topLeftY  = FLOOR_Y;
    assign visible   = vis_q;
    assign livesLeft = lives_q;
    assign hitPulse  = hit_q;
    assign gameOver  = over_q;

endmodule
